normalize_shift: RTL and testbench

- Multi-cycle post-add mantissa normalizer in the floating-point adder datapath.
- Sits directly upstream of the exponent increment/decrement stage and feeds it.
- Takes the raw mantissa sum, including the carry bit, and shifts it until the hidden bit is at bit MANT_W-1.
- Drives incre_en/incre_bit or decre_en/decre_bit so the exponent stage can adjust the selected exponent by the shift amount.

---
 rtl/fp_add_pkg.sv | 12 +
 rtl/normalize_shift.sv | 113 +++++++++++
 tb/tb_normalize_shift.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fp_add_pkg.sv
// Shared floating-point adder definitions: datapath widths and the
// normalizer state encoding.
package fp_add_pkg;
    localparam int MANT_W = 24;
    localparam int EXP_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } norm_state_t;
endpackage

// File: rtl/normalize_shift.sv
// Iterative post-add mantissa normalizer: one shift per cycle until the hidden
// bit lands at MANT_W-1, reporting the exponent adjustment to the next stage.
module normalize_shift
    import fp_add_pkg::*;
#(
    parameter int MANT_W = fp_add_pkg::MANT_W,
    parameter int EXP_W  = fp_add_pkg::EXP_W
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start,
    input  logic [MANT_W:0]   sum_mant,
    input  logic [EXP_W-1:0]  exp_in,
    output logic              busy,
    output logic              done,
    output logic [MANT_W-2:0] mant_out,
    output logic              guard,
    output logic              zero,
    output logic              underflow,
    output logic              incre_en,
    output logic              decre_en,
    output logic [EXP_W-1:0]  incre_bit,
    output logic [EXP_W-1:0]  decre_bit
);

    norm_state_t      state, state_nxt;
    logic [MANT_W:0]  mant_r;
    logic [EXP_W-1:0] exp_r;
    logic [EXP_W-1:0] cnt;
    logic             stop;
    logic             fin, inc_go, dec_go;

    // Any of the first four rules ends normalization this cycle.
    assign stop = (mant_r == '0) || mant_r[MANT_W] || mant_r[MANT_W-1] || (cnt == exp_r);

    always_ff @(posedge clk or negedge res) begin
        if (!res) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = NORM;
            NORM:    if (stop)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != IDLE);
        fin    = (state == DONE);
        inc_go = fin && (incre_bit != '0);
        dec_go = fin && (incre_bit == '0) && (cnt != '0);
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            mant_r    <= '0;
            exp_r     <= '0;
            cnt       <= '0;
            mant_out  <= '0;
            guard     <= 1'b0;
            zero      <= 1'b0;
            underflow <= 1'b0;
            incre_bit <= '0;
            decre_bit <= '0;
            done      <= 1'b0;
            incre_en  <= 1'b0;
            decre_en  <= 1'b0;
        end else begin
            done     <= fin;
            incre_en <= inc_go;
            decre_en <= dec_go;
            case (state)
                IDLE: if (start) begin
                    mant_r    <= sum_mant;
                    exp_r     <= exp_in;
                    cnt       <= '0;
                    guard     <= 1'b0;
                    zero      <= 1'b0;
                    underflow <= 1'b0;
                    incre_bit <= '0;
                    decre_bit <= '0;
                end
                NORM: begin
                    if (mant_r == '0) begin
                        zero <= 1'b1;
                    end else if (mant_r[MANT_W]) begin
                        mant_r    <= mant_r >> 1;
                        guard     <= mant_r[0];
                        incre_bit <= EXP_W'(1);
                    end else if (mant_r[MANT_W-1]) begin
                        mant_r <= mant_r;
                    end else if (cnt == exp_r) begin
                        // Denormal boundary: exponent cannot go any lower.
                        underflow <= 1'b1;
                    end else begin
                        mant_r <= mant_r << 1;
                        cnt    <= cnt + EXP_W'(1);
                    end
                end
                DONE: begin
                    decre_bit <= cnt;
                    mant_out  <= mant_r[MANT_W-2:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_normalize_shift.sv
// Directed-vector bench for normalize_shift: result table plus start-ignore
// and mid-operation reset sequences.
module tb_normalize_shift;
    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        start = 1'b0;
    logic [24:0] sum_mant = '0;
    logic [7:0]  exp_in = '0;
    logic        busy, done, guard, zero, underflow, incre_en, decre_en;
    logic [22:0] mant_out;
    logic [7:0]  incre_bit, decre_bit;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    normalize_shift dut (
        .clk(clk), .res(res), .start(start), .sum_mant(sum_mant), .exp_in(exp_in),
        .busy(busy), .done(done), .mant_out(mant_out), .guard(guard), .zero(zero),
        .underflow(underflow), .incre_en(incre_en), .decre_en(decre_en),
        .incre_bit(incre_bit), .decre_bit(decre_bit)
    );

    typedef struct {
        logic [24:0] sum;
        logic [7:0]  exp;
        int          lat;
        logic [22:0] mant;
        logic        g, z, u, ie, de;
        logic [7:0]  ib, db;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Start at edge 0 and return the cycle in which done is seen, or -1.
    task automatic run(input logic [24:0] s, input logic [7:0] e, output int lat);
        @(negedge clk);
        sum_mant = s; exp_in = e; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (done) begin lat = c; break; end
        end
    endtask

    initial begin
        int lat;
        logic [22:0] held;
        vecs[0] = '{25'h1800001, 8'd100,  2, 23'h400000, 1, 0, 0, 1, 0, 8'd1, 8'd0};
        vecs[1] = '{25'h0040000, 8'd100,  7, 23'h000000, 0, 0, 0, 0, 1, 8'd0, 8'd5};
        vecs[2] = '{25'h0000000, 8'd100,  2, 23'h000000, 0, 1, 0, 0, 0, 8'd0, 8'd0};
        vecs[3] = '{25'h0800000, 8'd100,  2, 23'h000000, 0, 0, 0, 0, 0, 8'd0, 8'd0};
        vecs[4] = '{25'h0000100, 8'd3,    5, 23'h000800, 0, 0, 1, 0, 1, 8'd0, 8'd3};
        vecs[5] = '{25'h1000000, 8'd100,  2, 23'h000000, 0, 0, 0, 1, 0, 8'd1, 8'd0};
        vecs[6] = '{25'h0400000, 8'd0,    2, 23'h400000, 0, 0, 1, 0, 0, 8'd0, 8'd0};
        vecs[7] = '{25'h0000001, 8'd100, 25, 23'h000000, 0, 0, 0, 0, 1, 8'd0, 8'd23};
        vecs[8] = '{25'h0FFFFFF, 8'd100,  2, 23'h7FFFFF, 0, 0, 0, 0, 0, 8'd0, 8'd0};
        vecs[9] = '{25'h1FFFFFF, 8'd100,  2, 23'h7FFFFF, 1, 0, 0, 1, 0, 8'd1, 8'd0};

        #12;
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset mant_out", 32'(mant_out), 0);
        chk("reset decre_bit", 32'(decre_bit), 0);
        @(negedge clk); res = 1'b1;

        foreach (vecs[i]) begin
            run(vecs[i].sum, vecs[i].exp, lat);
            chk($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d mant_out", i), 32'(mant_out), 32'(vecs[i].mant));
            chk($sformatf("v%0d guard", i), 32'(guard), 32'(vecs[i].g));
            chk($sformatf("v%0d zero", i), 32'(zero), 32'(vecs[i].z));
            chk($sformatf("v%0d underflow", i), 32'(underflow), 32'(vecs[i].u));
            chk($sformatf("v%0d incre_en", i), 32'(incre_en), 32'(vecs[i].ie));
            chk($sformatf("v%0d decre_en", i), 32'(decre_en), 32'(vecs[i].de));
            chk($sformatf("v%0d incre_bit", i), 32'(incre_bit), 32'(vecs[i].ib));
            chk($sformatf("v%0d decre_bit", i), 32'(decre_bit), 32'(vecs[i].db));
            held = mant_out;
            @(posedge clk); #1;
            chk($sformatf("v%0d done drop", i), 32'(done), 0);
            chk($sformatf("v%0d en drop", i), 32'({incre_en, decre_en}), 0);
            chk($sformatf("v%0d mant hold", i), 32'(mant_out), 32'(vecs[i].mant));
            chk($sformatf("v%0d bits hold", i), 32'({incre_bit, decre_bit}), 32'({vecs[i].ib, vecs[i].db}));
        end

        // Second start during NORM must be ignored.
        @(negedge clk);
        sum_mant = 25'h0040000; exp_in = 8'd100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        sum_mant = 25'h0; exp_in = 8'd0; start = 1'b1;
        chk("ign busy", 32'(busy), 1);
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        if (done) lat = 2;
        for (int c = 3; c <= 60 && lat < 0; c++) begin
            @(posedge clk); #1;
            if (done) lat = c;
        end
        chk("ign latency", 32'(lat), 7);
        chk("ign decre_bit", 32'(decre_bit), 5);
        chk("ign decre_en", 32'(decre_en), 1);
        chk("ign zero", 32'(zero), 0);
        chk("ign underflow", 32'(underflow), 0);

        // Reset mid-NORM clears everything and no done follows.
        @(negedge clk);
        sum_mant = 25'h0000001; exp_in = 8'd100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3 res = 1'b0;
        #1;
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst bits", 32'({incre_bit, decre_bit}), 0);
        chk("rst flags", 32'({guard, zero, underflow, incre_en, decre_en}), 0);
        chk("rst mant_out", 32'(mant_out), 0);
        @(negedge clk); res = 1'b1;
        lat = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done || busy) lat = 1;
        end
        chk("rst no done", 32'(lat), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
